// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
//   Shared constants, types and helpers for the register-file write-port
//   arbiter and its divider result queue.
//
//   Contents:
//     DEFAULT_XLEN          default register data width
//     DEFAULT_STARVE_LIMIT  default cycles a queued divider result may wait
//     DEFAULT_DIV_DEPTH     default divider result queue depth
//     REG_ADDR_W            register address width (x0..x31)
//     grant_e               owner of the write port in a given cycle
//     is_write_req()        "this is a real register write" qualifier
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  localparam int DEFAULT_XLEN         = 32;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int DEFAULT_DIV_DEPTH    = 2;
  localparam int REG_ADDR_W           = 5;

  // Who owns the register-file port this cycle.
  //   GRANT_NONE   : no write
  //   GRANT_PIPE   : in-order pipe result is written
  //   GRANT_DIV    : queue head is popped and written
  //   GRANT_RETIRE : stale queue head is popped without a write
  // A stale head may also be retired underneath GRANT_PIPE; that pop is
  // tracked separately because it does not use the port.
  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_PIPE   = 2'd1,
    GRANT_DIV    = 2'd2,
    GRANT_RETIRE = 2'd3
  } grant_e;

  // Writes to x0 are architecturally discarded, so they never count as a
  // request for the port.
  function automatic logic is_write_req(input logic                  we,
                                        input logic [REG_ADDR_W-1:0] addr);
    return we && (addr != '0);
  endfunction

endpackage

// File: rtl/wb_div_fifo.sv
// -----------------------------------------------------------------------------
// wb_div_fifo
//   Small ring-buffer queue holding divider results that are waiting for the
//   register-file write port. Each entry carries address, data, a valid bit
//   and a stale bit. A stale entry has been superseded by a younger pipe write
//   to the same register and must be retired without being written.
//
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     push, push_addr,
//     push_data            enqueue one entry (caller guarantees !full)
//     pop                  dequeue the head (ignored when empty)
//     mark_en, mark_addr   mark every valid entry with this address stale,
//                          including an entry being pushed in the same cycle
//     full, empty          occupancy flags
//     head_addr, head_data,
//     head_stale           head entry contents (meaningful when !empty)
// -----------------------------------------------------------------------------
module wb_div_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = DEFAULT_DIV_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  input  logic                  mark_en,
  input  logic [REG_ADDR_W-1:0] mark_addr,
  output logic                  full,
  output logic                  empty,
  output logic [REG_ADDR_W-1:0] head_addr,
  output logic [XLEN-1:0]       head_data,
  output logic                  head_stale
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      stale_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;

  logic do_push;
  logic do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // In a ring with per-slot valid bits the queue is full exactly when the
  // slot the write pointer addresses is still occupied, and empty when the
  // slot the read pointer addresses is free.
  assign full       = valid_q[wr_ptr_q];
  assign empty      = !valid_q[rd_ptr_q];
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign head_stale = stale_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Control state. The push slot is never the pop slot (push needs a free
  // slot, pop needs an occupied one), so the per-slot updates do not collide.
  // The pop clear is written after the address-match marking so a head that
  // is retired this cycle leaves no stale bit behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      stale_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mark_en && valid_q[i] && (addr_q[i] == mark_addr)) begin
          stale_q[i] <= 1'b1;
        end
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        stale_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      if (do_push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        // An arriving result is older than a pipe write accepted in the same
        // cycle, so it is born stale if the addresses match.
        stale_q[wr_ptr_q] <= mark_en && (mark_addr == push_addr);
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
    end
  end

  // Payload storage needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order
//   mem/writeback path ("pipe") and the out-of-order iterative mul/div unit
//   ("div"). Divider results are buffered in wb_div_fifo; the pipe normally
//   wins the port, but a divider result that has waited STARVE_LIMIT cycles
//   preempts the pipe for one cycle. A divider result whose register was
//   overwritten by a younger pipe write is retired without writing.
//
//   Ports:
//     clk_i, rst_i                      clock, synchronous active-high reset
//     pipe_rd_addr_i/data_i/we_i        in-order write request
//     pipe_ready_o                      pipe write accepted (0 = stall)
//     div_valid_i, div_rd_addr_i,
//     div_data_i, div_ready_o           divider result channel
//     rd_addr_o, rd_data_o, rd_we_o     registered register-file write port
//
//   Handshakes:
//     div: a transfer happens on a rising edge where div_valid_i and
//       div_ready_o are both 1. div_ready_o depends only on queue occupancy
//       (never on div_valid_i); a producer holding valid must keep its
//       address/data stable until the transfer. Transfers to x0 complete
//       but are dropped.
//     pipe: a write request (we=1, addr!=0) is consumed on a rising edge
//       where pipe_ready_o=1; while pipe_ready_o=0 upstream holds its inputs.
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int DIV_DEPTH    = DEFAULT_DIV_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] pipe_rd_addr_i,
  input  logic [XLEN-1:0]       pipe_rd_data_i,
  input  logic                  pipe_rd_we_i,
  output logic                  pipe_ready_o,
  input  logic                  div_valid_i,
  input  logic [REG_ADDR_W-1:0] div_rd_addr_i,
  input  logic [XLEN-1:0]       div_data_i,
  output logic                  div_ready_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  rd_we_o
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  // Queue interface
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic                  head_stale;
  logic                  div_push;
  logic                  head_pop;

  // Arbitration
  logic                  pipe_req;
  logic                  pipe_accept;
  grant_e                grant;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;

  // Starvation tracking
  logic [AGE_W-1:0]      age_q;
  logic [AGE_W-1:0]      age_d;
  logic                  starve_q;

  // ---------------------------------------------------------------------------
  // Divider queue
  // ---------------------------------------------------------------------------
  assign div_ready_o = !fifo_full;
  assign div_push    = div_valid_i && !fifo_full && (div_rd_addr_i != '0);

  assign pipe_req     = is_write_req(pipe_rd_we_i, pipe_rd_addr_i);
  assign pipe_ready_o = !starve_q;
  assign pipe_accept  = pipe_req && !starve_q;

  wb_div_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DIV_DEPTH)
  ) u_div_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (div_push),
    .push_addr  (div_rd_addr_i),
    .push_data  (div_data_i),
    .pop        (head_pop),
    .mark_en    (pipe_accept),
    .mark_addr  (pipe_rd_addr_i),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .head_stale (head_stale)
  );

  // ---------------------------------------------------------------------------
  // Grant: starved head > pipe > queued head. A stale head never needs the
  // port, so it is popped whenever it is at the head, even while the pipe
  // writes.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant    = GRANT_NONE;
    head_pop = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = pipe_rd_addr_i;
    wr_data  = pipe_rd_data_i;

    if (starve_q) begin
      head_pop = 1'b1;
      grant    = head_stale ? GRANT_RETIRE : GRANT_DIV;
    end else if (pipe_req) begin
      grant    = GRANT_PIPE;
      head_pop = !fifo_empty && head_stale;
    end else if (!fifo_empty) begin
      head_pop = 1'b1;
      grant    = head_stale ? GRANT_RETIRE : GRANT_DIV;
    end

    case (grant)
      GRANT_PIPE: begin
        wr_en = 1'b1;
      end
      GRANT_DIV: begin
        wr_en   = 1'b1;
        wr_addr = head_addr;
        wr_data = head_data;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Age of the current head: counts cycles a live head is passed over by the
  // pipe. A head that is not popped is always live (stale heads are popped
  // immediately), so "not popped and not empty" means "waiting".
  // ---------------------------------------------------------------------------
  always_comb begin
    age_d = age_q;
    if (head_pop || fifo_empty) begin
      age_d = '0;
    end else if (!head_stale && (age_q != AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      age_q    <= age_d;
      starve_q <= (age_d == AGE_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port. Address/data hold their last value when no write
  // is granted; rd_we_o alone qualifies them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_we_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      rd_we_o <= wr_en;
      if (wr_en) begin
        rd_addr_o <= wr_addr;
        rd_data_o <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed table of cycle vectors, hand-written reset sequence, and a
//   randomized phase, all scored against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;
  localparam int DEPTH = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4:0]      pipe_rd_addr_i = '0;
  logic [XLEN-1:0] pipe_rd_data_i = '0;
  logic            pipe_rd_we_i   = 1'b0;
  logic            pipe_ready_o;
  logic            div_valid_i    = 1'b0;
  logic [4:0]      div_rd_addr_i  = '0;
  logic [XLEN-1:0] div_data_i     = '0;
  logic            div_ready_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            rd_we_o;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN         (XLEN),
    .STARVE_LIMIT (LIMIT),
    .DIV_DEPTH    (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pipe_rd_addr_i (pipe_rd_addr_i),
    .pipe_rd_data_i (pipe_rd_data_i),
    .pipe_rd_we_i   (pipe_rd_we_i),
    .pipe_ready_o   (pipe_ready_o),
    .div_valid_i    (div_valid_i),
    .div_rd_addr_i  (div_rd_addr_i),
    .div_data_i     (div_data_i),
    .div_ready_o    (div_ready_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_o      (rd_data_o),
    .rd_we_o        (rd_we_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: divider results waiting in a queue, each knowing whether
  // a younger pipe write has overwritten its register; the head's waiting
  // time in cycles; the write expected on the port after the next edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    bit              stale;
  } m_entry_t;

  m_entry_t        m_q[$];
  int              m_wait;
  logic            m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  bit              last_p_acc;
  bit              last_d_acc;
  logic            obs_pr;
  logic            obs_dr;
  logic [XLEN-1:0] rf [32];

  // One clock cycle: drive inputs, check ready outputs before the edge,
  // advance the model, check the registered write after the edge.
  task automatic step(input bit r,
                      input logic pwe, input logic [4:0] pa, input logic [XLEN-1:0] pd,
                      input logic dv,  input logic [4:0] da, input logic [XLEN-1:0] dd);
    bit       starve, full, preq, pop, was_empty;
    m_entry_t e;
    @(negedge clk);
    rst = r;
    pipe_rd_we_i = pwe; pipe_rd_addr_i = pa; pipe_rd_data_i = pd;
    div_valid_i = dv;   div_rd_addr_i = da;  div_data_i = dd;
    #1;
    obs_pr = pipe_ready_o;
    obs_dr = div_ready_o;
    if (r) begin
      m_q.delete();
      m_wait = 0; m_we = 0; m_addr = '0; m_data = '0;
      last_p_acc = 1; last_d_acc = 1;
    end else begin
      was_empty = (m_q.size() == 0);
      full   = (m_q.size() == DEPTH);
      starve = !was_empty && (m_wait >= LIMIT);
      check("pipe_ready", obs_pr, !starve);
      check("div_ready", obs_dr, !full);
      preq = pwe && (pa != 0);
      pop  = 0;
      m_we = 0;
      if (starve || (!preq && !was_empty)) begin
        pop = 1;
        if (!m_q[0].stale) begin
          m_we = 1; m_addr = m_q[0].addr; m_data = m_q[0].data;
        end
      end else if (preq) begin
        m_we = 1; m_addr = pa; m_data = pd;
        pop = !was_empty && m_q[0].stale;
      end
      last_p_acc = !starve;
      last_d_acc = dv && !full;
      if (pop) void'(m_q.pop_front());
      if (last_d_acc && (da != 0)) begin
        e.addr = da; e.data = dd; e.stale = 0;
        m_q.push_back(e);
      end
      if (preq && !starve) begin
        foreach (m_q[i]) begin
          if (m_q[i].addr == pa) begin
            e = m_q[i]; e.stale = 1; m_q[i] = e;
          end
        end
      end
      if (pop || was_empty) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
    end
    @(posedge clk);
    #1;
    if (r) begin
      check("reset_we", rd_we_o, 0);
      check("reset_addr", rd_addr_o, 0);
      check("reset_data", rd_data_o, 0);
    end else begin
      check("rd_we", rd_we_o, m_we);
      if (m_we) begin
        check("rd_addr", rd_addr_o, m_addr);
        check("rd_data", rd_data_o, m_data);
      end
    end
    if (rd_we_o) rf[rd_addr_o] = rd_data_o;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs for one cycle, ready outputs expected in that
  // cycle, write port expected after its edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic pwe; logic [4:0] pa; logic [31:0] pd;
    logic dv;  logic [4:0] da; logic [31:0] dd;
    logic epr; logic edr; logic ewe; logic [4:0] ea; logic [31:0] ed;
  } vec_t;

  localparam int N_TBL = 27;
  vec_t tbl [N_TBL];

  function automatic vec_t v(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                             input logic dv, input logic [4:0] da, input logic [31:0] dd,
                             input logic epr, input logic edr,
                             input logic ewe, input logic [4:0] ea, input logic [31:0] ed);
    vec_t t;
    t.pwe = pwe; t.pa = pa; t.pd = pd; t.dv = dv; t.da = da; t.dd = dd;
    t.epr = epr; t.edr = edr; t.ewe = ewe; t.ea = ea; t.ed = ed;
    return t;
  endfunction

  initial begin
    logic            pwe, dv;
    logic [4:0]      pa, da;
    logic [XLEN-1:0] pd, dd;
    int              pprob;

    foreach (rf[i]) rf[i] = '0;

    //            pwe pa  pd      dv da  dd      pr dr we addr data
    tbl[0]  = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);      // idle after reset
    tbl[1]  = v(1, 5,  'h11,   0, 0,  0,      1, 1, 1, 5,  'h11);   // pipe x5
    tbl[2]  = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);
    tbl[3]  = v(0, 0,  0,      1, 7,  'hAB,   1, 1, 0, 0,  0);      // div x7 accepted
    tbl[4]  = v(0, 0,  0,      0, 0,  0,      1, 1, 1, 7,  'hAB);   // written 2 cycles on
    tbl[5]  = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);
    tbl[6]  = v(0, 0,  0,      1, 3,  'h33,   1, 1, 0, 0,  0);      // div x3 queued
    tbl[7]  = v(1, 1,  'h01,   0, 0,  0,      1, 1, 1, 1,  'h01);
    tbl[8]  = v(1, 2,  'h02,   0, 0,  0,      1, 1, 1, 2,  'h02);
    tbl[9]  = v(1, 4,  'h04,   0, 0,  0,      1, 1, 1, 4,  'h04);
    tbl[10] = v(1, 6,  'h06,   0, 0,  0,      1, 1, 1, 6,  'h06);
    tbl[11] = v(1, 8,  'h08,   0, 0,  0,      0, 1, 1, 3,  'h33);   // starved head preempts
    tbl[12] = v(1, 8,  'h08,   0, 0,  0,      1, 1, 1, 8,  'h08);   // held pipe x8
    tbl[13] = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);
    tbl[14] = v(0, 0,  0,      1, 9,  'h1,    1, 1, 0, 0,  0);      // div x9=1 queued
    tbl[15] = v(1, 9,  'h2,    0, 0,  0,      1, 1, 1, 9,  'h2);    // pipe x9=2
    tbl[16] = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);      // stale head retired
    tbl[17] = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);
    tbl[18] = v(1, 11, 'hB1,   1, 10, 'hA0,   1, 1, 1, 11, 'hB1);
    tbl[19] = v(1, 13, 'hD3,   1, 12, 'hC2,   1, 1, 1, 13, 'hD3);
    tbl[20] = v(1, 15, 'hF5,   1, 14, 'hE4,   1, 0, 1, 15, 'hF5);   // queue full
    tbl[21] = v(1, 16, 'h16,   1, 14, 'hE4,   1, 0, 1, 16, 'h16);
    tbl[22] = v(0, 0,  0,      1, 14, 'hE4,   1, 0, 1, 10, 'hA0);   // pop, push still blocked
    tbl[23] = v(0, 0,  0,      1, 14, 'hE4,   1, 1, 1, 12, 'hC2);   // x14 accepted
    tbl[24] = v(0, 0,  0,      1, 0,  'h99,   1, 1, 1, 14, 'hE4);   // x0 accepted, dropped
    tbl[25] = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);
    tbl[26] = v(0, 0,  0,      0, 0,  0,      1, 1, 0, 0,  0);

    // Reset for a few cycles.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);

    // Directed table.
    for (int i = 0; i < N_TBL; i++) begin
      step(0, tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].dv, tbl[i].da, tbl[i].dd);
      check($sformatf("tbl%0d_pready", i), obs_pr, tbl[i].epr);
      check($sformatf("tbl%0d_dready", i), obs_dr, tbl[i].edr);
      check($sformatf("tbl%0d_we", i), rd_we_o, tbl[i].ewe);
      if (tbl[i].ewe) begin
        check($sformatf("tbl%0d_addr", i), rd_addr_o, tbl[i].ea);
        check($sformatf("tbl%0d_data", i), rd_data_o, tbl[i].ed);
      end
    end
    check("rf_x9_final", rf[9], 'h2);
    check("rf_x0_untouched", rf[0], 0);

    // Reset with two queued entries: they must never be written.
    step(0, 1, 20, 'h20, 1, 21, 'h21);
    step(0, 1, 22, 'h22, 1, 23, 'h23);
    check("two_queued_full", div_ready_o, 0);
    step(1, 1, 24, 'h24, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    check("abandon_x21", rf[21], 0);
    check("abandon_x23", rf[23], 0);

    // Randomized traffic with a legal upstream: hold until accepted.
    pwe = 0; pa = 0; pd = 0; dv = 0; da = 0; dd = 0;
    for (int i = 0; i < 600; i++) begin
      pprob = ((i / 100) % 2 == 0) ? 90 : 45;
      if (last_p_acc) begin
        pwe = ($urandom_range(0, 99) < pprob);
        pa  = 5'($urandom_range(0, 7));
        pd  = $urandom;
      end
      if (!dv || last_d_acc) begin
        dv = ($urandom_range(0, 99) < 45);
        da = 5'($urandom_range(0, 7));
        dd = $urandom;
      end
      if ($urandom_range(0, 249) == 0) begin
        step(1, pwe, pa, pd, dv, da, dd);
        dv = 0;
      end else begin
        step(0, pwe, pa, pd, dv, da, dd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN (32), register data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, max cycles a queued divider result waits before it preempts the pipeline.
REQ-003 SHALL have parameter DIV_DEPTH, default 2, divider result queue entries.
REQ-004 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have ports pipe_rd_addr_i in 5, pipe_rd_data_i in XLEN, pipe_rd_we_i in 1: in-order result from the mem/writeback path.
REQ-007 SHALL have port pipe_ready_o  out  1  pipe write accepted this cycle; when 0, upstream holds its inputs stable (stall).
REQ-008 SHALL have ports div_valid_i in 1, div_rd_addr_i in 5, div_data_i in XLEN, div_ready_o out 1: valid/ready result channel from the iterative mul/div unit.
REQ-009 SHALL have ports rd_addr_o out 5, rd_data_o out XLEN, rd_we_o out 1: registered register-file write port.

Function
REQ-010 SHALL treat a pipe request as present only when pipe_rd_we_i=1 and pipe_rd_addr_i!=0; otherwise no request, no write.
REQ-011 SHALL accept a div transfer when div_valid_i && div_ready_o; div_ready_o = queue not full (no same-cycle pop bypass).
REQ-012 SHALL accept and discard div transfers with div_rd_addr_i=0 (no queue push).
REQ-013 SHALL grant per cycle: if starve_q=1, queue head; else if pipe request, pipe; else if queue non-empty, queue head.
REQ-014 SHALL drive pipe_ready_o = !starve_q (also 1 when no pipe request).
REQ-015 SHALL register the granted write: rd_we_o/rd_addr_o/rd_data_o valid the cycle after grant; rd_we_o=0 in cycles with no granted write; pipe latency 1, minimum div latency 2 (accept -> rd_we_o).
REQ-016 SHALL pop the queue head on grant; on head pop rd_we_o=0 if the head is stale.
REQ-017 SHALL pop a stale head in the same cycle the pipe is granted (stale retirement uses no port).
REQ-018 SHALL, on every accepted pipe write to address A, mark stale all valid queue entries with address A, including a div entry pushed that same cycle (contract: queued/arriving div results are always older than concurrent or later pipe writes).
REQ-019 SHALL keep age counter: +1 each cycle head is valid, non-stale and not granted; cleared on pop or empty; saturates at STARVE_LIMIT; starve_q=1 when count==STARVE_LIMIT.
REQ-020 SHALL support simultaneous push and pop; full->push blocked even when pop occurs that cycle.
REQ-021 SHALL preserve FIFO order among div results; pipe writes never reordered.

Reset
REQ-022 SHALL on rst_i=1 clear rd_we_o, rd_addr_o, rd_data_o to 0, empty the queue, clear stale bits, age counter and starve_q.
REQ-023 SHALL present pipe_ready_o=1 and div_ready_o=1 in the first cycle after reset release.
REQ-024 SHALL abandon queued div results on reset mid-operation without writing them.

Structure
REQ-025 SHALL take XLEN from defines.v; DIV_DEPTH and STARVE_LIMIT defaults as `defines in defines.v.
REQ-026 SHALL implement the queue (data, addr, valid, stale bits, address-match stale marking) as sub-module wb_div_fifo; grant logic, age counter and output register stay in wb_port_arbiter.

Verification
REQ-027 SHALL cover: pipe write x5=0x11 with queue empty -> next cycle rd_we_o=1, rd_addr_o=5, rd_data_o=0x11; pipe_ready_o=1 throughout.
REQ-028 SHALL cover: div x7=0xAB while pipe idle -> rd_we_o=1, addr 7, data 0xAB two cycles after acceptance.
REQ-029 SHALL cover: div x3 queued, pipe writes x1,x2,x4,x6,x8 back-to-back -> after 4 waiting cycles pipe_ready_o=0 one cycle, x3 written, pipe held data x8 written next cycle.
REQ-030 SHALL cover: div x9=0x1 queued, then pipe x9=0x2 accepted -> regfile ends with x9=0x2; head retired with rd_we_o=0.
REQ-031 SHALL cover: two div pushes with pipe busy -> div_ready_o=0; third push held until pop, then accepted; order preserved; div x0 accepted, never written.
REQ-032 SHALL cover: rst_i asserted with 2 queued entries -> all outputs 0 next cycle, no queued write appears after release.
